// File: rtl/conv_layer_mem_responder.sv
// Memory-side responder for the CONV engine: image ROM, L0/L1 result banks, start handshake, result dump.
// Latency: idata/cdata_rd are combinational reads; dump words are registered and follow an accepted word by one clock.
// Backpressure: dump_valid is held with stable sel/addr/data/last until dump_ready; one word per clock when ready stays high.
//
// Ports:
//   clk, reset (async, active low)
//   ld_valid/ld_addr/ld_data/ld_done : host image load
//   ready/busy                       : start handshake with CONV
//   iaddr/idata                      : CONV image read
//   cwr/caddr_wr/cdata_wr            : CONV layer write
//   crd/caddr_rd/cdata_rd/csel       : CONV layer read and bank select (001 = L0, 011 = L1)
//   dump_valid/dump_ready/dump_sel/dump_addr/dump_data/dump_last : result stream to host
//   done, err                        : sticky status
module conv_layer_mem_responder #(
  parameter int AW       = 12,
  parameter int DW       = 20,
  parameter int L1_DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_done,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          dump_sel,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_last,
  output logic          done,
  output logic          err
);

  localparam int              L0_DEPTH = 1 << AW;
  localparam int              L1W      = $clog2(L1_DEPTH);
  localparam logic [AW:0]     L1_LIMIT = (AW+1)'(L1_DEPTH);
  localparam logic [AW-1:0]   L0_LAST  = '1;
  localparam logic [AW-1:0]   L1_LAST  = AW'(L1_DEPTH - 1);
  localparam logic [2:0]      CSEL_L0  = 3'b001;
  localparam logic [2:0]      CSEL_L1  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DUMP_L0,
    S_DUMP_L1,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] img_mem [L0_DEPTH];
  logic [DW-1:0] l0_mem  [L0_DEPTH];
  logic [DW-1:0] l1_mem  [L1_DEPTH];

  logic          busy_q;
  logic          run;
  logic          sel_l0;
  logic          sel_l1;
  logic          wr_in_l1;
  logic          rd_in_l1;
  logic          wr_legal;
  logic          rd_legal;
  logic          img_we;
  logic          l0_we;
  logic          l1_we;
  logic          illegal;
  logic          dump_xfer;
  logic          dump_start;
  logic [AW-1:0] dump_addr_inc;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign run      = (state == S_RUN);
  assign sel_l0   = (csel == CSEL_L0);
  assign sel_l1   = (csel == CSEL_L1);
  // Zero-extended compare so the check also holds if L1 ever spans the full address range.
  assign wr_in_l1 = ({1'b0, caddr_wr} < L1_LIMIT);
  assign rd_in_l1 = ({1'b0, caddr_rd} < L1_LIMIT);
  assign wr_legal = sel_l0 || (sel_l1 && wr_in_l1);
  assign rd_legal = sel_l0 || (sel_l1 && rd_in_l1);

  assign img_we   = ld_valid && ((state == S_IDLE) || (state == S_LOAD));
  assign l0_we    = run && cwr && sel_l0;
  assign l1_we    = run && cwr && sel_l1 && wr_in_l1;
  assign illegal  = run && ((cwr && !wr_legal) || (crd && !rd_legal));

  assign dump_xfer     = dump_valid && dump_ready;
  assign dump_addr_inc = dump_addr + AW'(1);

  // ---------------------------------------------------------------------------
  // Memories: no reset, contents survive a reset pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (img_we) begin
      img_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (l0_we) begin
      l0_mem[caddr_wr] <= cdata_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (l1_we) begin
      l1_mem[caddr_wr[L1W-1:0]] <= cdata_wr;
    end
  end

  assign idata = img_mem[iaddr];

  // Read is combinational off the array, so a same-cycle write to the same
  // address returns the old word; the new word lands at the clock edge.
  always_comb begin
    cdata_rd = '0;
    if (run && crd) begin
      if (sel_l0) begin
        cdata_rd = l0_mem[caddr_rd];
      end else if (sel_l1 && rd_in_l1) begin
        cdata_rd = l1_mem[caddr_rd[L1W-1:0]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= busy;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_valid) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (ld_done) state_nxt = S_ARM;
      end
      S_ARM: begin
        // ready falls in the very cycle busy is first seen.
        ready = !busy;
        if (busy) state_nxt = S_RUN;
      end
      S_RUN: begin
        // RUN is only entered with busy high, so busy_q is 1 on entry and the
        // falling edge marks the end of the CONV pass.
        if (busy_q && !busy) state_nxt = S_DUMP_L0;
      end
      S_DUMP_L0: begin
        if (dump_xfer && (dump_addr == L0_LAST)) state_nxt = S_DUMP_L1;
      end
      S_DUMP_L1: begin
        if (dump_xfer && (dump_addr == L1_LAST)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign dump_start = run && (state_nxt == S_DUMP_L0);

  // ---------------------------------------------------------------------------
  // Sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Dump stream: the output registers always hold the word being offered;
  // on acceptance the next word is fetched from the bank in the same clock.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_valid <= 1'b0;
      dump_sel   <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else if (dump_start) begin
      dump_valid <= 1'b1;
      dump_sel   <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= l0_mem[0];
      dump_last  <= 1'b0;
    end else if (dump_xfer) begin
      if (!dump_sel && (dump_addr == L0_LAST)) begin
        // L0 exhausted: address wraps and the stream switches to L1.
        dump_sel  <= 1'b1;
        dump_addr <= '0;
        dump_data <= l1_mem[0];
        dump_last <= (L1_DEPTH == 1);
      end else if (dump_sel && (dump_addr == L1_LAST)) begin
        dump_valid <= 1'b0;
        dump_last  <= 1'b0;
      end else begin
        dump_addr <= dump_addr_inc;
        dump_data <= dump_sel ? l1_mem[dump_addr_inc[L1W-1:0]] : l0_mem[dump_addr_inc];
        dump_last <= dump_sel && (dump_addr_inc == L1_LAST);
      end
    end
  end

endmodule
